// File: rtl/shared_adder_scheduler.sv
// shared_adder_scheduler: round-robin time-sharing of one ripple-carry adder among four requesters
module shared_ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  wire [WIDTH:0]   c;
  wire [WIDTH-1:0] p;
  wire [WIDTH-1:0] g;
  wire [WIDTH-1:0] t;
  wire [WIDTH-1:0] s;
  assign c[0]   = cin_i;
  assign sum_o  = s;
  assign cout_o = c[WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    xor u_p (p[i], a_i[i], b_i[i]);
    xor u_s (s[i], p[i], c[i]);
    and u_g (g[i], a_i[i], b_i[i]);
    and u_t (t[i], p[i], c[i]);
    or  u_c (c[i+1], g[i], t[i]);
  end
endmodule

module shared_adder_scheduler #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_in,
  input  logic [4*WIDTH-1:0] b_in,
  input  logic [3:0]         cin_in,
  output logic [3:0]         gnt,
  output logic               busy,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout,
  output logic               res_valid,
  output logic [1:0]         res_id,
  output logic [WIDTH-1:0]   res_sum,
  output logic               res_cout
);
  typedef enum logic {IDLE, SETTLE} state_t;
  state_t           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       cur_id_q, cur_id_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic             res_valid_q, res_valid_d;
  logic [1:0]       res_id_q, res_id_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  logic [7:0]       dbl;
  logic [3:0]       rot;
  logic [1:0]       win;
  logic             term;
  logic             arb;
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  // Rotate requests so the search starts at the pointer, take the first set bit, rotate back.
  always_comb begin
    dbl  = {req, req} >> ptr_q;
    rot  = dbl[3:0];
    win  = ptr_q + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
    term = (state_q == SETTLE) && (count_q == 4'(SETTLE_CYCLES - 1));
    arb  = ((state_q == IDLE) || term) && (req != 4'b0000);
  end
  // Next state: capture on the last settle edge, and (re)grant on any edge where the adder frees up.
  always_comb begin
    state_d     = state_q;
    count_d     = (state_q == SETTLE) ? count_q + 4'd1 : count_q;
    ptr_d       = ptr_q;
    cur_id_d    = cur_id_q;
    gnt_d       = 4'b0000;
    busy_d      = busy_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    if (term) begin
      res_valid_d = 1'b1;
      res_id_d    = cur_id_q;
      res_sum_d   = add_sum;
      res_cout_d  = add_cout;
      count_d     = 4'd0;
      busy_d      = 1'b0;
      state_d     = IDLE;
    end
    if (arb) begin
      gnt_d     = 4'b0001 << win;
      add_a_d   = a_in[32'(win)*WIDTH +: WIDTH];
      add_b_d   = b_in[32'(win)*WIDTH +: WIDTH];
      add_cin_d = cin_in[win];
      cur_id_d  = win;
      ptr_d     = win + 2'd1;
      count_d   = 4'd0;
      busy_d    = 1'b1;
      state_d   = SETTLE;
    end
  end
  // State register; reset abandons any in-flight addition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= 4'd0;
      ptr_q       <= 2'd0;
      cur_id_q    <= 2'd0;
      gnt_q       <= 4'b0000;
      busy_q      <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 2'd0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      cur_id_q    <= cur_id_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
    end
  end
endmodule

// File: tb/tb_shared_adder_scheduler.sv
// tb_shared_adder_scheduler: scoreboard bench for two builds (settle 4 and settle 1) on shared stimulus
module tb_shared_adder_scheduler;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] cin_in = 4'b0000;
  logic [4*W-1:0] a_in = '0;
  logic [4*W-1:0] b_in = '0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  task automatic chk(input int cfg, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, name, act, exp, $time);
    end
  endtask
  task automatic set_op(input int i, input int a, input int b, input logic c);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
    cin_in[i]      = c;
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int S = (g == 0) ? 4 : 1;
    logic [3:0]   gnt;
    logic         busy, add_cin, add_cout, res_valid, res_cout;
    logic [1:0]   res_id;
    logic [W-1:0] add_a, add_b, add_sum, res_sum;
    shared_adder_scheduler #(.WIDTH(W), .SETTLE_CYCLES(S)) u_dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
      .gnt(gnt), .busy(busy), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout), .res_valid(res_valid), .res_id(res_id),
      .res_sum(res_sum), .res_cout(res_cout)
    );
    shared_ripple_adder #(.WIDTH(W)) u_add (
      .a_i(add_a), .b_i(add_b), .cin_i(add_cin), .sum_o(add_sum), .cout_o(add_cout)
    );
    int rem = 0;
    int nxt = 0;
    int w = 0;
    logic [3:0]   m_gnt = 4'b0000;
    logic         m_res = 1'b0;
    logic         m_rst = 1'b1;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic         m_cin = 1'b0;
    logic [W:0]   s;
    logic [W+2:0] e;
    logic [W+2:0] sb[$];
    // Reference: a busy timer of S edges per job; a free adder takes the first requester from nxt onward.
    always @(posedge clk) begin
      m_res = 1'b0;
      m_gnt = 4'b0000;
      m_rst = rst;
      if (rst) begin
        rem = 0; nxt = 0; m_a = '0; m_b = '0; m_cin = 1'b0;
        sb.delete();
      end else begin
        if (rem > 0) begin
          rem--;
          m_res = (rem == 0);
        end
        if (rem == 0 && req != 4'b0000) begin
          w = nxt;
          while (!req[w]) w = (w + 1) % 4;
          nxt   = (w + 1) % 4;
          m_gnt = 4'b0001 << w;
          m_a   = a_in[w*W +: W];
          m_b   = b_in[w*W +: W];
          m_cin = cin_in[w];
          s     = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};
          sb.push_back({2'(w), s});
          rem   = S;
        end
      end
    end
    // Monitor: compare every registered output against the reference; pop a result on each res_valid.
    always @(negedge clk) begin
      chk(g, "gnt", 32'(gnt), 32'(m_gnt));
      chk(g, "busy", 32'(busy), 32'(rem > 0));
      chk(g, "add_a", 32'(add_a), 32'(m_a));
      chk(g, "add_b", 32'(add_b), 32'(m_b));
      chk(g, "add_cin", 32'(add_cin), 32'(m_cin));
      chk(g, "res_valid", 32'(res_valid), 32'(m_res));
      if (m_rst) begin
        chk(g, "rst_res_id", 32'(res_id), 32'd0);
        chk(g, "rst_res_sum", 32'(res_sum), 32'd0);
        chk(g, "rst_res_cout", 32'(res_cout), 32'd0);
      end
      if (res_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL cfg%0d res_unexpected: got res_valid=1 expected no result at %0t", g, $time);
        end else begin
          e = sb.pop_front();
          chk(g, "res_id", 32'(res_id), 32'(e[W+2:W+1]));
          chk(g, "res_sum", 32'(res_sum), 32'(e[W-1:0]));
          chk(g, "res_cout", 32'(res_cout), 32'(e[W]));
        end
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_op(0, 3, 5, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    repeat (6) @(negedge clk);
    set_op(2, 15, 1, 1'b1);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    set_op(2, 6, 9, 1'b0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) set_op(i, i + 1, 2 * i + 3, i[0]);
    req = 4'b1111;
    repeat (20) @(negedge clk);
    req = 4'b0000;
    repeat (5) @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0011;
    repeat (6) @(negedge clk);
    req = 4'b0000;
    repeat (5) @(negedge clk);
    req = 4'b1010;
    repeat (10) @(negedge clk);
    req = 4'b0000;
    repeat (5) @(negedge clk);
    set_op(3, 9, 9, 1'b1);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1001;
    repeat (10) @(negedge clk);
    req = 4'b0000;
    repeat (5) @(negedge clk);
    set_op(1, 7, 9, 1'b0);
    req = 4'b0010;
    repeat (4) @(negedge clk);
    req = 4'b0000;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      req    = 4'($urandom);
      a_in   = (4*W)'($urandom);
      b_in   = (4*W)'($urandom);
      cin_in = 4'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    req = 4'b0000;
    repeat (10) @(negedge clk);
    chk(0, "drain", 32'(g_cfg[0].sb.size()), 32'd0);
    chk(1, "drain", 32'(g_cfg[1].sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
